// File: rtl/alu_result_stage.sv
// alu_result_stage
//   EX/MEM stage sitting directly behind the 16-bit ALU. Each accepted ALU
//   result (r, zero, ovfl, rd, wen) is captured into a two-entry skid buffer
//   so that a stall from memory/writeback never loses a result. Results leave
//   in strict FIFO order, and every hand-off to the consumer is counted.
//
//   Optional feature macro: OVFL_TRAP_EN
//     defined   : a signed-overflow ADD/SUB is not buffered; it raises trap
//                 (with trap_rd) and blocks input until trap_ack.
//     undefined : trap/trap_rd tied low, overflowed results buffered normally.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake (accept = in_valid & in_ready)
//   in_r/zero/ovfl/op/rd/wen  ALU result and destination info
//   flush                     drop all buffered entries at the next edge
//   out_valid/out_ready       downstream handshake (fire = out_valid & out_ready)
//   out_r/zero/ovfl/rd/wen    head entry; holds last value while out_valid=0
//   retire_cnt                number of fires since reset, wraps at 16 bits
//   trap/trap_rd/trap_ack     overflow trap status and clear
module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic              in_zero,
  input  logic              in_ovfl,
  input  logic [OP_W-1:0]   in_op,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic              out_zero,
  output logic              out_ovfl,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [15:0]       retire_cnt,
  output logic              trap,
  output logic [RD_W-1:0]   trap_rd,
  input  logic              trap_ack
);

  // Entry layout: {r, zero, ovfl, rd, wen}
  localparam int ENT_W = DATA_W + 3 + RD_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_next;
  logic [ENT_W-1:0] head, skid, in_ent;
  logic             accept, fire, store, trap_hit;
  logic             load_head_in, load_head_skid, load_skid;

  assign in_ent = {in_r, in_zero, in_ovfl, in_rd, in_wen};

  // in_ready depends on registered state only, never on inputs.
  assign in_ready  = (state != TWO) & ~trap;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  // A trapping result is consumed by the handshake but never stored.
  assign store     = accept & ~trap_hit;

  assign {out_r, out_zero, out_ovfl, out_rd, out_wen} = head;

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Same-cycle accept is dropped; data registers simply hold.
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (store) begin
            state_next   = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (store && fire) begin
            load_head_in = 1'b1;
          end else if (store) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state_next     = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_next;
      if (load_head_in)   head <= in_ent;
      if (load_head_skid) head <= skid;
      if (load_skid)      skid <= in_ent;
    end
  end

  // Fires during a flush still retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt <= 16'd0;
    else if (fire) retire_cnt <= retire_cnt + 16'd1;
  end

`ifdef OVFL_TRAP_EN
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);

  assign trap_hit = accept & in_ovfl & ((in_op == OP_ADD) | (in_op == OP_SUB));

  // in_ready is low while trap is set, so a new hit cannot coincide with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap    <= 1'b0;
      trap_rd <= '0;
    end else if (trap_hit && !flush) begin
      trap    <= 1'b1;
      trap_rd <= in_rd;
    end else if (trap && trap_ack) begin
      trap    <= 1'b0;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{in_op, trap_ack};
  assign trap_hit = 1'b0;
  assign trap     = 1'b0;
  assign trap_rd  = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_r = '0;
  logic        in_zero = 1'b0, in_ovfl = 1'b0;
  logic [3:0]  in_op = '0, in_rd = '0;
  logic        in_wen = 1'b0, flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_r;
  logic        out_zero, out_ovfl;
  logic [3:0]  out_rd;
  logic        out_wen;
  logic [15:0] retire_cnt;
  logic        trap;
  logic [3:0]  trap_rd;
  logic        trap_ack = 1'b0;

  alu_result_stage #(.DATA_W(16), .RD_W(4), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_zero(in_zero), .in_ovfl(in_ovfl), .in_op(in_op),
    .in_rd(in_rd), .in_wen(in_wen), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_zero(out_zero), .out_ovfl(out_ovfl),
    .out_rd(out_rd), .out_wen(out_wen),
    .retire_cnt(retire_cnt),
    .trap(trap), .trap_rd(trap_rd), .trap_ack(trap_ack)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of results plus the last displayed entry.
  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        o;
    logic [3:0]  rd;
    logic        w;
  } ent_t;

  ent_t        q[$];
  ent_t        m_last;
  logic [15:0] m_cnt;
  logic        m_trap;
  logic [3:0]  m_trap_rd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last    = '0;
    m_cnt     = 16'd0;
    m_trap    = 1'b0;
    m_trap_rd = 4'd0;
  endtask

  task automatic compare_all();
    chk("out_valid",  out_valid,  q.size() > 0);
    chk("in_ready",   in_ready,   (q.size() < 2) && !m_trap);
    chk("out_r",      out_r,      m_last.r);
    chk("out_zero",   out_zero,   m_last.z);
    chk("out_ovfl",   out_ovfl,   m_last.o);
    chk("out_rd",     out_rd,     m_last.rd);
    chk("out_wen",    out_wen,    m_last.w);
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("trap",       trap,       m_trap);
    chk("trap_rd",    trap_rd,    m_trap_rd);
  endtask

  // Apply current inputs for one clock, advance the model, then compare.
  task automatic step(input bit do_chk);
    bit   rdy, acc, fire, hit;
    ent_t e;
    rdy  = (q.size() < 2) && !m_trap;
    acc  = in_valid && rdy;
    fire = (q.size() > 0) && out_ready;
    hit  = 1'b0;
`ifdef OVFL_TRAP_EN
    hit = acc && in_ovfl && (in_op == 4'd1 || in_op == 4'd2);
    if (m_trap && trap_ack) m_trap = 1'b0;
    if (hit && !flush) begin
      m_trap    = 1'b1;
      m_trap_rd = in_rd;
    end
`endif
    e = '{r: in_r, z: in_zero, o: in_ovfl, rd: in_rd, w: in_wen};
    if (fire) begin
      m_cnt = m_cnt + 16'd1;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (acc && !hit) q.push_back(e);
    if (q.size() > 0) m_last = q[0];
    @(posedge clk);
    #1;
    if (do_chk) compare_all();
  endtask

  task automatic drive(input bit v, input logic [15:0] r, input logic [3:0] rd);
    in_valid = v;
    in_r     = r;
    in_rd    = rd;
    in_zero  = (r == 16'd0);
    in_ovfl  = 1'b0;
    in_op    = 4'd0;
    in_wen   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    drive(1'b0, 16'd0, 4'd0);
    do_reset();
    compare_all();
    chk("reset_in_ready", in_ready, 1'b1);

    // Single result passes straight through, then retires.
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 4'd3);
    step(1);
    chk("t2_out_r", out_r, 16'h1234);
    chk("t2_out_rd", out_rd, 4'd3);
    drive(1'b0, 16'h0, 4'd0);
    step(1);
    chk("t2_retire", retire_cnt, 16'd1);

    // Fill both entries, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 4'd1);
    step(1);
    drive(1'b1, 16'h0002, 4'd2);
    step(1);
    chk("t3_full_ready", in_ready, 1'b0);
    chk("t3_head_first", out_r, 16'h0001);
    drive(1'b0, 16'h0, 4'd0);
    out_ready = 1'b1;
    step(1);
    chk("t3_head_second", out_r, 16'h0002);
    chk("t3_ready_again", in_ready, 1'b1);
    step(1);
    chk("t3_drained", out_valid, 1'b0);

    // Flush with a same-cycle input while full.
    out_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 4'd4);
    step(1);
    drive(1'b1, 16'h0B0B, 4'd6);
    step(1);
    drive(1'b1, 16'h00FF, 4'd7);
    flush = 1'b1;
    step(1);
    chk("t4_flush_valid", out_valid, 1'b0);
    chk("t4_no_00ff", out_r != 16'h00FF, 1'b1);
    flush = 1'b0;
    drive(1'b0, 16'h0, 4'd0);
    step(1);
    chk("t4_no_00ff_later", out_r != 16'h00FF, 1'b1);

    // Asynchronous reset between edges with two entries held.
    drive(1'b1, 16'h1111, 4'd1);
    step(1);
    drive(1'b1, 16'h2222, 4'd2);
    step(1);
    drive(1'b0, 16'h0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_rst_valid", out_valid, 1'b0);
    chk("t1_rst_ready", in_ready, 1'b1);
    chk("t1_rst_cnt", retire_cnt, 16'd0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    compare_all();

    // Overflowing ADD.
    out_ready = 1'b0;
    drive(1'b1, 16'h8000, 4'd5);
    in_op   = 4'b0001;
    in_ovfl = 1'b1;
    step(1);
    drive(1'b0, 16'h0, 4'd0);
`ifdef OVFL_TRAP_EN
    chk("t5_trap", trap, 1'b1);
    chk("t5_trap_rd", trap_rd, 4'd5);
    chk("t5_blocked", in_ready, 1'b0);
    chk("t5_not_stored", out_valid, 1'b0);
    trap_ack = 1'b1;
    step(1);
    trap_ack = 1'b0;
    chk("t5_trap_clear", trap, 1'b0);
    chk("t5_ready", in_ready, 1'b1);
`else
    chk("t5_out_ovfl", out_ovfl, 1'b1);
    chk("t5_out_rd", out_rd, 4'd5);
    chk("t5_trap_low", trap, 1'b0);
    trap_ack  = 1'b1;
    out_ready = 1'b1;
    step(1);
    trap_ack = 1'b0;
    chk("t5_trap_still_low", trap, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_r      = 16'($urandom);
      in_zero   = $urandom_range(0, 1) == 1;
      in_ovfl   = $urandom_range(0, 3) == 0;
      in_op     = 4'($urandom_range(0, 3));
      in_rd     = 4'($urandom);
      in_wen    = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      trap_ack  = ($urandom_range(0, 3) == 0);
      step(1);
    end
    flush    = 1'b0;
    trap_ack = 1'b1;
    drive(1'b0, 16'h0, 4'd0);
    step(1);
    trap_ack = 1'b0;

    // Counter wrap: exactly 65536 fires after reset.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'h5555, 4'd9);
    step(1);
    for (int i = 0; i < 65535; i++) begin
      in_r = 16'(i);
      step(i % 4096 == 0);
    end
    drive(1'b0, 16'h0, 4'd0);
    step(1);
    chk("t6_wrap", retire_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
